// File: rtl/ikaz_buzzer_surucu.sv
//==============================================================================
// Module      : ikaz_buzzer_surucu
// Description : Turns the seat-belt and door warning levels into a timed
//               buzzer pattern. The door alarm has priority. The seat-belt
//               alarm escalates to a continuous tone after YUKSELT_SAYISI
//               completed beeps.
//               Optional macro IKAZ_SUSTUR_EN adds a driver mute (SUSTUR state).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module ikaz_buzzer_surucu #(
    parameter int TICK_DIV       = 1000,
    parameter int KEMER_ON_MS    = 200,
    parameter int KEMER_OFF_MS   = 800,
    parameter int KAPI_ON_MS     = 100,
    parameter int KAPI_OFF_MS    = 100,
    parameter int YUKSELT_SAYISI = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       emniyet_kemeri_ikaz_i,
    input  logic       kapi_ikaz_i,
    input  logic       sustur_i,
    output logic       buzzer_o,
    output logic [2:0] durum_o,
    output logic [7:0] bip_sayac_o
);

    typedef enum logic [2:0] {
        BEKLE     = 3'd0,
        KEMER_ON  = 3'd1,
        KEMER_OFF = 3'd2,
        KAPI_ON   = 3'd3,
        KAPI_OFF  = 3'd4,
        SUREKLI   = 3'd5,
        SUSTUR    = 3'd6
    } durum_t;

    // Longest phase in ms decides the width of the ms counter.
    localparam int MAX_AB = (KEMER_ON_MS > KEMER_OFF_MS) ? KEMER_ON_MS : KEMER_OFF_MS;
    localparam int MAX_CD = (KAPI_ON_MS > KAPI_OFF_MS) ? KAPI_ON_MS : KAPI_OFF_MS;
    localparam int MAX_MS = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int PW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int MW     = $clog2(MAX_MS + 1);

    durum_t          durum;
    durum_t          sonraki;
    logic [PW-1:0]   presc;
    logic [MW-1:0]   ms_say;
    logic [MW-1:0]   faz_son;
    logic            faz_bitti;
    logic            zamanli;
    logic [7:0]      bip_sayac;
    logic [7:0]      bip_artmis;
    logic            buzzer;

`ifndef IKAZ_SUSTUR_EN
    // Mute input has no function in this build.
    logic unused_sustur;
    assign unused_sustur = sustur_i;
`endif

    // Last ms index of the current timed phase and end-of-phase detection.
    always_comb begin
        faz_son = '0;
        zamanli = 1'b1;
        case (durum)
            KEMER_ON:  faz_son = MW'(KEMER_ON_MS - 1);
            KEMER_OFF: faz_son = MW'(KEMER_OFF_MS - 1);
            KAPI_ON:   faz_son = MW'(KAPI_ON_MS - 1);
            KAPI_OFF:  faz_son = MW'(KAPI_OFF_MS - 1);
            default:   zamanli = 1'b0;
        endcase
        faz_bitti  = zamanli && (presc == PW'(TICK_DIV - 1)) && (ms_say == faz_son);
        bip_artmis = (bip_sayac == 8'hFF) ? 8'hFF : bip_sayac + 8'd1;
    end

    // Next-state selection: input priority rules first, then phase timer, mute last.
    always_comb begin
        sonraki = durum;
        if (kapi_ikaz_i && !(durum inside {KAPI_ON, KAPI_OFF, SUSTUR})) begin
            sonraki = KAPI_ON;
        end else if (!kapi_ikaz_i && emniyet_kemeri_ikaz_i &&
                     (durum inside {BEKLE, KAPI_ON, KAPI_OFF})) begin
            sonraki = KEMER_ON;
        end else if (!kapi_ikaz_i && !emniyet_kemeri_ikaz_i && (durum != BEKLE)) begin
            sonraki = BEKLE;
        end else if (faz_bitti) begin
            case (durum)
                KEMER_ON:  sonraki = (bip_artmis == 8'(YUKSELT_SAYISI)) ? SUREKLI : KEMER_OFF;
                KEMER_OFF: sonraki = KEMER_ON;
                KAPI_ON:   sonraki = KAPI_OFF;
                KAPI_OFF:  sonraki = KAPI_ON;
                default:   sonraki = durum;
            endcase
        end
`ifdef IKAZ_SUSTUR_EN
        // A mute pulse overrides every other transition once an alarm is active.
        if (sustur_i && (durum != BEKLE)) begin
            sonraki = SUSTUR;
        end
`endif
    end

    // State, registered outputs, phase timers and beep counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            durum     <= BEKLE;
            buzzer    <= 1'b0;
            presc     <= '0;
            ms_say    <= '0;
            bip_sayac <= 8'd0;
        end else begin
            durum  <= sonraki;
            buzzer <= (sonraki inside {KEMER_ON, KAPI_ON, SUREKLI});

            // Timers restart on every state entry and only run in timed phases.
            if ((sonraki != durum) || !zamanli) begin
                presc  <= '0;
                ms_say <= '0;
            end else if (presc == PW'(TICK_DIV - 1)) begin
                presc  <= '0;
                ms_say <= ms_say + MW'(1);
            end else begin
                presc  <= presc + PW'(1);
            end

            // Count clears on entry to idle/door/mute; a completed belt beep bumps it.
            if ((sonraki != durum) && (sonraki inside {BEKLE, KAPI_ON, SUSTUR})) begin
                bip_sayac <= 8'd0;
            end else if ((durum == KEMER_ON) && (sonraki inside {KEMER_OFF, SUREKLI})) begin
                bip_sayac <= bip_artmis;
            end
        end
    end

    assign buzzer_o    = buzzer;
    assign durum_o     = durum;
    assign bip_sayac_o = bip_sayac;

endmodule

`default_nettype wire
